uart_rx_engine: RTL

- Parametrised UART receive engine: line synchroniser, oversampled bit timing, shift register and framing FSM in one block.
- Configurable data width, parity mode and stop-bit count per frame.
- Majority-vote sampling, false-start rejection, break detection and overrun reporting.
- Sits between the RX pin and the RX queue; writes one word per good frame and raises error pulses for the interrupt/status logic.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_sync.sv | 25 ++
 rtl/uart_rx_engine.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive and transmit paths.
package uart_pkg;

   typedef enum logic [1:0] {
      PARITY_NONE = 2'b00,
      PARITY_EVEN = 2'b01,
      PARITY_ODD  = 2'b10,
      PARITY_RSVD = 2'b11
   } parity_mode_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP1  = 3'd4,
      STOP2  = 3'd5,
      BREAK  = 3'd6
   } rx_state_t;

   localparam int MIN_DATA_BITS = 5;

   // Clamp a requested data width into MIN_DATA_BITS..max_bits.
   function automatic logic [3:0] clamp_data_bits(input logic [3:0] req, input int max_bits);
      logic [3:0] res;
      res = req;
      if (int'(req) < MIN_DATA_BITS) begin
         res = 4'(MIN_DATA_BITS);
      end else if (int'(req) > max_bits) begin
         res = 4'(max_bits);
      end
      return res;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-stage synchroniser for an asynchronous serial line; resets to the
// idle-high level so a reset never looks like a start edge.
module uart_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_ff;

   // Shift the raw line through the flop chain every clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_ff <= '1;
      end else begin
         sync_ff <= {sync_ff[STAGES-2:0], d};
      end
   end

   assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronised line, oversampled majority-vote bit
// timing, shift register and framing FSM producing one queue write per
// good frame plus one-clock error pulses.
//
// Queue handshake: rx_queue_we is a one-clock push strobe with no
// back-pressure. rx_queue_full is looked at only on the frame completion
// cycle; if it is high then, the word is dropped and overrun_error pulses
// instead of rx_queue_we. rx_data is valid in the strobe cycle and holds
// until the next write.
module uart_rx_engine
   import uart_pkg::*;
#(
   parameter int MAX_DATA_BITS = 9,
   parameter int OVERSAMPLE    = 16,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rx_clk_en,
   input  logic                     rx,
   input  logic [3:0]               data_bits,
   input  logic [1:0]               parity_mode,
   input  logic                     double_stop_bit,
   input  logic                     rx_queue_full,
   output logic [MAX_DATA_BITS-1:0] rx_data,
   output logic                     rx_queue_we,
   output logic                     parity_error,
   output logic                     frame_error,
   output logic                     break_detect,
   output logic                     overrun_error,
   output logic                     busy
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int HALF  = OVERSAMPLE / 2;
   localparam logic [CNT_W-1:0] CNT_LO     = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(HALF);
   localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(HALF + 1);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(OVERSAMPLE - 1);

   // FSM state; a plain named register so checkers can bind to it.
   rx_state_t                state;
   logic                     synced;
   logic                     prev;
   logic                     s_lo;
   logic                     s_mid;
   logic [CNT_W-1:0]         sample_cnt;
   logic [3:0]               bit_cnt;
   logic [3:0]               nbits_q;
   parity_mode_t             pmode_q;
   logic                     dstop_q;
   logic                     par_acc;
   logic                     parity_bad;
   logic                     stop1_q;
   logic                     all_zero;
   logic [MAX_DATA_BITS-1:0] rx_data_shift;

   logic                     at_decide;
   logic                     at_wrap;
   logic                     majority;
   logic                     parity_en;
   logic                     frame_done;
   logic                     first_stop;
   logic                     stops_ok;
   logic                     is_break;
   logic [MAX_DATA_BITS-1:0] aligned;

   uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (synced)
   );

   // Bit-timing decode, majority vote and frame-completion classification.
   always_comb begin
      at_decide  = (sample_cnt == CNT_DECIDE);
      at_wrap    = (sample_cnt == CNT_LAST);
      majority   = (s_lo & s_mid) | (s_lo & synced) | (s_mid & synced);
      parity_en  = (pmode_q == PARITY_EVEN) || (pmode_q == PARITY_ODD);
      frame_done = rx_clk_en && at_decide &&
                   (((state == STOP1) && !dstop_q) || (state == STOP2));
      // In STOP2 the first stop bit was recorded earlier; in STOP1 it is
      // the bit being decided now.
      first_stop = (state == STOP2) ? stop1_q : majority;
      stops_ok   = first_stop & majority;
      is_break   = all_zero & ~first_stop;
      // Bits enter at the MSB end, so a short word must be shifted down.
      aligned    = rx_data_shift >> (MAX_DATA_BITS - int'(nbits_q));
   end

   // Framing FSM, counters, shift register and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         prev          <= 1'b1;
         s_lo          <= 1'b1;
         s_mid         <= 1'b1;
         sample_cnt    <= '0;
         bit_cnt       <= '0;
         nbits_q       <= '0;
         pmode_q       <= PARITY_NONE;
         dstop_q       <= 1'b0;
         par_acc       <= 1'b0;
         parity_bad    <= 1'b0;
         stop1_q       <= 1'b1;
         all_zero      <= 1'b0;
         rx_data_shift <= '0;
         rx_data       <= '0;
         rx_queue_we   <= 1'b0;
         parity_error  <= 1'b0;
         frame_error   <= 1'b0;
         break_detect  <= 1'b0;
         overrun_error <= 1'b0;
         busy          <= 1'b0;
      end else begin
         rx_queue_we   <= 1'b0;
         parity_error  <= 1'b0;
         frame_error   <= 1'b0;
         break_detect  <= 1'b0;
         overrun_error <= 1'b0;

         if (rx_clk_en) begin
            prev <= synced;
            if (state != IDLE) begin
               sample_cnt <= at_wrap ? '0 : sample_cnt + 1'b1;
               if (sample_cnt == CNT_LO) s_lo <= synced;
               if (sample_cnt == CNT_MID) s_mid <= synced;
            end

            case (state)
               IDLE: begin
                  if (prev && !synced) begin
                     sample_cnt    <= '0;
                     nbits_q       <= clamp_data_bits(data_bits, MAX_DATA_BITS);
                     pmode_q       <= parity_mode_t'(parity_mode);
                     dstop_q       <= double_stop_bit;
                     rx_data_shift <= '0;
                     par_acc       <= 1'b0;
                     parity_bad    <= 1'b0;
                     stop1_q       <= 1'b1;
                     all_zero      <= 1'b1;
                     state         <= START;
                     busy          <= 1'b1;
                  end
               end
               START: begin
                  if (at_decide) begin
                     if (majority) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end else begin
                        bit_cnt <= '0;
                     end
                  end else if (at_wrap) begin
                     state <= DATA;
                  end
               end
               DATA: begin
                  if (at_decide) begin
                     rx_data_shift <= {majority, rx_data_shift[MAX_DATA_BITS-1:1]};
                     par_acc       <= par_acc ^ majority;
                     bit_cnt       <= bit_cnt + 4'd1;
                     if (majority) all_zero <= 1'b0;
                  end else if (at_wrap && (bit_cnt == nbits_q)) begin
                     state <= parity_en ? PARITY : STOP1;
                  end
               end
               PARITY: begin
                  if (at_decide) begin
                     parity_bad <= (pmode_q == PARITY_ODD) ? ~(par_acc ^ majority)
                                                           : (par_acc ^ majority);
                     if (majority) all_zero <= 1'b0;
                  end else if (at_wrap) begin
                     state <= STOP1;
                  end
               end
               STOP1: begin
                  if (at_decide && dstop_q) begin
                     stop1_q <= majority;
                  end else if (at_wrap && dstop_q) begin
                     state <= STOP2;
                  end
               end
               STOP2: begin
                  // Completion is handled below on the decision tick.
               end
               BREAK: begin
                  if (synced) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase

            // Frame completion: outcomes are mutually exclusive, highest first.
            if (frame_done) begin
               if (is_break) begin
                  break_detect <= 1'b1;
                  state        <= BREAK;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (!stops_ok) begin
                     frame_error <= 1'b1;
                  end else if (parity_bad) begin
                     parity_error <= 1'b1;
                  end else if (rx_queue_full) begin
                     overrun_error <= 1'b1;
                  end else begin
                     rx_queue_we <= 1'b1;
                     rx_data     <= aligned;
                  end
               end
            end
         end
      end
   end

endmodule
